// File: rtl/monobit_pkg.sv
// monobit_pkg: shared types and constants for the monobit frequency tester.
// Holds the FSM state enum, default block size / threshold and counter widths.
package monobit_pkg;

    // Default block length is 2^DEF_N_LOG2 bits.
    localparam int DEF_N_LOG2 = 7;

    // |S_n| <= 29 corresponds to p >= 0.01 at N = 128.
    localparam int DEF_THRESH = 29;

    // One extra bit so the ones count can hold N itself.
    localparam int CNT_W = DEF_N_LOG2 + 1;

    // Failed-block counter width.
    localparam int FAIL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/monobit_eval.sv
// monobit_eval: registered |2*ones - N| and threshold verdict.
// Ports: clk, rst (async, active high), load (capture strobe),
//        ones (block ones count), abs_sum / pass (held until next load).
module monobit_eval
    import monobit_pkg::*;
#(
    parameter int N_LOG2 = DEF_N_LOG2,
    parameter int THRESH = DEF_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [N_LOG2:0]   ones,
    output logic [N_LOG2:0]   abs_sum,
    output logic              pass
);

    localparam int CW = N_LOG2 + 1;
    localparam logic [CW-1:0] HALF = CW'(1) << (N_LOG2 - 1);
    localparam logic [31:0]   THR  = 32'(THRESH);

    logic [CW-1:0] dev;
    logic [CW-1:0] abs_next;
    logic          pass_next;

    // |2*ones - N| == 2*|ones - N/2|. Working around N/2 keeps every
    // intermediate within CW bits: the deviation is at most N/2, so
    // doubling it never exceeds N.
    always_comb begin
        dev       = '0;
        abs_next  = '0;
        pass_next = 1'b0;
        if (ones >= HALF) begin
            dev = ones - HALF;
        end else begin
            dev = HALF - ones;
        end
        abs_next  = dev + dev;
        pass_next = (32'(abs_next) <= THR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abs_sum <= '0;
            pass    <= 1'b0;
        end else if (load) begin
            abs_sum <= abs_next;
            pass    <= pass_next;
        end
    end

endmodule

// File: rtl/monobit_tester.sv
// monobit_tester: NIST SP800-22 monobit test over blocks of 2^N_LOG2 bits.
// Ports: clk, rst (async, active high); start, abort, bit_valid, bit_in
//        control/sample inputs; busy, result_valid (1-cycle pulse), pass,
//        ones_cnt, abs_sum (held) and fail_cnt outputs.
// Build option: define MONOBIT_FAILCNT_EN to enable the saturating
//        failed-block counter; otherwise fail_cnt is tied to zero.
module monobit_tester
    import monobit_pkg::*;
#(
    parameter int N_LOG2 = DEF_N_LOG2,
    parameter int THRESH = DEF_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              busy,
    output logic              result_valid,
    output logic              pass,
    output logic [N_LOG2:0]   ones_cnt,
    output logic [N_LOG2:0]   abs_sum,
    output logic [FAIL_W-1:0] fail_cnt
);

    localparam int CW = N_LOG2 + 1;

    state_t state_q;
    state_t state_d;

    logic [N_LOG2-1:0] bit_cnt;
    logic [CW-1:0]     ones_acc;
    logic [CW-1:0]     ones_next;
    logic [CW-1:0]     ones_q;

    logic clr;
    logic acc;
    logic last_bit;

    // Counter control. abort outranks both start and bit_valid.
    always_comb begin
        clr       = 1'b0;
        acc       = 1'b0;
        last_bit  = 1'b0;
        ones_next = ones_acc + CW'(bit_in);
        if (state_q == IDLE) begin
            clr = start && !abort;
        end
        if (state_q == ACCUM) begin
            clr = abort;
            acc = !abort && bit_valid;
        end
        // Bit counter all-ones means this accepted sample is the Nth.
        last_bit = acc && (bit_cnt == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            ones_acc <= '0;
            ones_q   <= '0;
        end else begin
            if (clr) begin
                bit_cnt  <= '0;
                ones_acc <= '0;
            end else if (acc) begin
                bit_cnt  <= bit_cnt + N_LOG2'(1);
                ones_acc <= ones_next;
            end
            // Capture with the Nth bit so results are valid in DONE.
            if (last_bit) begin
                ones_q <= ones_next;
            end
        end
    end

    assign ones_cnt = ones_q;

    monobit_eval #(
        .N_LOG2 (N_LOG2),
        .THRESH (THRESH)
    ) u_eval (
        .clk     (clk),
        .rst     (rst),
        .load    (last_bit),
        .ones    (ones_next),
        .abs_sum (abs_sum),
        .pass    (pass)
    );

`ifdef MONOBIT_FAILCNT_EN
    logic [FAIL_W-1:0] fail_q;

    // Counts in the DONE cycle using the verdict already held there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q <= '0;
        end else if (state_q == DONE && !pass && fail_q != '1) begin
            fail_q <= fail_q + FAIL_W'(1);
        end
    end

    assign fail_cnt = fail_q;
`else
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_monobit_tester.sv
// tb_monobit_tester: directed + randomized checks of monobit_tester
// against an arithmetic model of the monobit statistic.
module tb_monobit_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       bit_in;

    logic       busy, result_valid, pass;
    logic [7:0] ones_cnt, abs_sum, fail_cnt;

    logic       busy2, rv2, pass2;
    logic [7:0] oc2, as2, fc2;

    int checks = 0;
    int errors = 0;

    // Model state: held results and failing blocks since reset.
    int exp_ones = 0;
    int exp_abs  = 0;
    int exp_pass = 0;
    int fails    = 0;

    always #5 clk = ~clk;

    monobit_tester #(.N_LOG2(7), .THRESH(29)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .busy         (busy),
        .result_valid (result_valid),
        .pass         (pass),
        .ones_cnt     (ones_cnt),
        .abs_sum      (abs_sum),
        .fail_cnt     (fail_cnt)
    );

    monobit_tester #(.N_LOG2(7), .THRESH(30)) dut30 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .busy         (busy2),
        .result_valid (rv2),
        .pass         (pass2),
        .ones_cnt     (oc2),
        .abs_sum      (as2),
        .fail_cnt     (fc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int fail_exp();
`ifdef MONOBIT_FAILCNT_EN
        return (fails > 255) ? 255 : fails;
`else
        return 0;
`endif
    endfunction

    task automatic check_held(input string tag);
        chk({tag, "_ones"}, 32'(ones_cnt), 32'(exp_ones));
        chk({tag, "_abs"},  32'(abs_sum),  32'(exp_abs));
        chk({tag, "_pass"}, 32'(pass),     32'(exp_pass));
        chk({tag, "_fcnt"}, 32'(fail_cnt), 32'(fail_exp()));
    endtask

    // One full block; v[i] is the i-th sample. A stray bit_valid rides
    // along with start and a start is held during DONE: both must be
    // ignored.
    task automatic run_block(input logic [127:0] v, input bit gaps,
                             input string tag);
        int ones, dev, i, guard;
        bit bad;
        ones = $countones(v);
        dev  = 2 * ones - 128;
        if (dev < 0) dev = -dev;
        @(negedge clk);
        start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        start = 1'b0; bit_valid = 1'b0;
        bad = 1'b0; i = 0; guard = 0;
        while (i < 128) begin
            guard++;
            if (gaps && guard < 2000 && $urandom_range(1, 0) == 0) begin
                bit_valid = 1'b0;
            end else begin
                bit_valid = 1'b1;
                bit_in    = v[i];
                i++;
            end
            @(negedge clk);
            if (i < 128 && (busy !== 1'b1 || result_valid !== 1'b0))
                bad = 1'b1;
        end
        bit_valid = 1'b0;
        start     = 1'b1;
        exp_ones  = ones;
        exp_abs   = dev;
        exp_pass  = (dev <= 29) ? 1 : 0;
        chk({tag, "_accum"}, 32'(bad), 32'(0));
        chk({tag, "_rv"},    32'(result_valid), 32'(1));
        chk({tag, "_busy"},  32'(busy), 32'(1));
        chk({tag, "_ones"},  32'(ones_cnt), 32'(exp_ones));
        chk({tag, "_abs"},   32'(abs_sum), 32'(exp_abs));
        chk({tag, "_pass"},  32'(pass), 32'(exp_pass));
        chk({tag, "_pass30"}, 32'(pass2), 32'((dev <= 30) ? 1 : 0));
        if (exp_pass == 0) fails++;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_rv_off"},  32'(result_valid), 32'(0));
        chk({tag, "_idle"},    32'(busy), 32'(0));
        chk({tag, "_fcnt"},    32'(fail_cnt), 32'(fail_exp()));
    endtask

    initial begin
        logic [127:0] v;
        bit bad;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rv",   32'(result_valid), 32'(0));
        check_held("rst");
        @(negedge clk);
        rst = 1'b0;

        // All ones: maximum deviation.
        v = '1;
        run_block(v, 1'b0, "ones");

        // Alternating 0,1.
        v = {64{2'b10}};
        run_block(v, 1'b0, "alt");

        // Threshold boundary.
        v = (128'd1 << 78) - 128'd1;
        run_block(v, 1'b0, "b78");
        v = (128'd1 << 79) - 128'd1;
        run_block(v, 1'b0, "b79");

        // Alternating with random bit_valid gaps.
        v = {64{2'b10}};
        run_block(v, 1'b1, "altgap");

        // Abort after 60 bits; abort beats a concurrent bit_valid.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        abort = 1'b0; bit_valid = 1'b0;
        chk("abort_idle", 32'(busy), 32'(0));
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) bad = 1'b1;
        end
        chk("abort_no_rv", 32'(bad), 32'(0));
        check_held("abort_held");

        // start and abort together in IDLE: stays idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort", 32'(busy), 32'(0));

        v = '0;
        run_block(v, 1'b0, "zeros");

        // Asynchronous reset mid-block.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        exp_ones = 0; exp_abs = 0; exp_pass = 0; fails = 0;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_rv",   32'(result_valid), 32'(0));
        check_held("mid_rst");
        @(negedge clk);
        rst = 1'b0; bit_valid = 1'b0;

        // Randomized blocks, with and without gaps.
        for (int r = 0; r < 6; r++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            if (r >= 3) begin
                // Bias toward the threshold region.
                v = (128'd1 << $urandom_range(84, 44)) - 128'd1;
            end
            run_block(v, 1'(r % 2), "rand");
        end

`ifdef MONOBIT_FAILCNT_EN
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_ones = 0; exp_abs = 0; exp_pass = 0; fails = 0;
        @(negedge clk);
        rst = 1'b0;
        v = '1;
        for (int k = 0; k < 3; k++) run_block(v, 1'b0, "fc");
        chk("fcnt3", 32'(fail_cnt), 32'(3));
        for (int k = 0; k < 297; k++) run_block(v, 1'b0, "fc");
        chk("fcnt_sat", 32'(fail_cnt), 32'(255));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
